// File: rtl/clock_phase_pkg.sv
// Shared types and defaults for the clock phase generator.
package clock_phase_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_CH_W   = 3;

    // Packs four half-periods with channel 0 in the least-significant slot.
    function automatic logic [4*DEF_CNT_W-1:0] pack_half4(
        input logic [DEF_CNT_W-1:0] h0,
        input logic [DEF_CNT_W-1:0] h1,
        input logic [DEF_CNT_W-1:0] h2,
        input logic [DEF_CNT_W-1:0] h3
    );
        return {h3, h2, h1, h0};
    endfunction

    localparam logic [4*DEF_CNT_W-1:0] DEF_RST_HALF = pack_half4(8'd1, 8'd2, 8'd2, 8'd4);

endpackage

// File: rtl/clock_phase_channel.sv
// One derived-clock channel: half-period counter with a reload that only lands
// at a phase boundary, so reprogramming never produces a runt pulse.
module clock_phase_channel
    import clock_phase_pkg::*;
#(
    parameter int               CNT_W    = DEF_CNT_W,
    parameter logic [CNT_W-1:0] RST_HALF = CNT_W'(1)
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             adv_i,
    input  logic             resync_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_half_i,
    output logic             pending_o,
    output logic             clk_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] nxt_q, nxt_d;
    logic [CNT_W-1:0] h_use;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             apply_now;

    always_comb begin
        cnt_d     = cnt_q;
        half_d    = half_q;
        nxt_d     = nxt_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
        pend_d    = pend_q;
        apply_now = 1'b0;
        h_use     = half_q;

        if (cfg_we_i) begin
            nxt_d  = cfg_half_i;
            pend_d = 1'b1;
        end

        if (resync_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (pend_d) begin
                half_d = nxt_d;
                pend_d = 1'b0;
            end
        end else begin
            // Low and at the start of its phase: safe to swap the half-period now.
            apply_now = pend_q && !clk_q && (cnt_q == '0);
            if (apply_now) begin
                h_use  = nxt_q;
                half_d = nxt_q;
                pend_d = 1'b0;
            end
            if (adv_i) begin
                if (h_use == '0) begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                end else if (cnt_q == h_use - CNT_W'(1)) begin
                    cnt_d  = '0;
                    clk_d  = !clk_q;
                    tick_d = !clk_q;
                    if (clk_q && pend_q) begin
                        half_d = nxt_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            cnt_q  <= '0;
            half_q <= RST_HALF;
            nxt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            nxt_q  <= nxt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;
    assign clk_o     = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clock_phase_gen.sv
// Multi-channel programmable clock generator with halt/single-step and resync.
// state   | meaning
// RUN     | channels advance every master cycle
// HALT    | channels frozen; a step pulse advances them one cycle
module clock_phase_gen
    import clock_phase_pkg::*;
#(
    parameter int                      NUM_CH   = DEF_NUM_CH,
    parameter int                      CNT_W    = DEF_CNT_W,
    parameter int                      CH_W     = DEF_CH_W,
    parameter logic [NUM_CH*CNT_W-1:0] RST_HALF = DEF_RST_HALF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              resync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              halted
);

    localparam int               NSEL     = 1 << CH_W;
    localparam logic [CH_W:0]    NUM_CH_W = (CH_W + 1)'(NUM_CH);

    state_e            state_q, state_d;
    logic              adv;
    logic              accept;
    logic              in_range;
    logic              cfg_err_q;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] cfg_we;
    logic [NSEL-1:0]   pend_pad;

    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (run) begin
                    adv = 1'b1;
                end else begin
                    state_d = ST_HALT;
                    adv     = step;
                end
            end
            ST_HALT: begin
                if (run) begin
                    state_d = ST_RUN;
                    adv     = 1'b1;
                end else begin
                    adv = step;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= accept && !in_range;
        end
    end

    // Unused select codes read as "not pending", so out-of-range requests are always ready.
    always_comb begin
        pend_pad = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pend_pad[i] = pending[i];
        end
    end

    assign in_range  = {1'b0, cfg_ch} < NUM_CH_W;
    assign cfg_ready = !pend_pad[cfg_ch];
    assign accept    = cfg_valid && cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign cfg_we[i] = accept && (cfg_ch == CH_W'(i));

        clock_phase_channel #(
            .CNT_W    (CNT_W),
            .RST_HALF (RST_HALF[i*CNT_W +: CNT_W])
        ) u_ch (
            .clock_i    (clock),
            .reset_ni   (reset),
            .adv_i      (adv),
            .resync_i   (resync),
            .cfg_we_i   (cfg_we[i]),
            .cfg_half_i (cfg_half),
            .pending_o  (pending[i]),
            .clk_o      (clk_out[i]),
            .tick_o     (tick[i])
        );
    end

    assign cfg_err = cfg_err_q;
    assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_clock_phase_gen.sv
// Scoreboard bench for clock_phase_gen: a phase-remaining reference model
// predicts {clk_out, tick, halted, cfg_err} for every master cycle.
module tb_clock_phase_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b1;
    logic       step = 1'b0;
    logic       resync = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_ch = 3'd0;
    logic [7:0] cfg_half = 8'd0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       halted;
    logic [3:0] clk_out;
    logic [3:0] tick;

    always #5 clock = ~clock;

    clock_phase_gen dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .resync    (resync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .halted    (halted)
    );

    logic [9:0] obs;
    assign obs = {clk_out, tick, halted, cfg_err};

    logic [9:0] sb[$];
    logic [9:0] e;
    int n_chk = 0;
    int n_err = 0;
    int tk_cnt[4];

    // Reference model: per channel, cycles remaining in the current phase.
    int RST[4] = '{1, 2, 2, 4};
    bit m_clk[4];
    int m_rem[4];
    int m_half[4];
    int m_nxt[4];
    bit m_pend[4];
    bit m_halt = 1'b0;
    bit m_err = 1'b0;

    function automatic bit m_ready(input int ch);
        return (ch >= 4) || !m_pend[ch];
    endfunction

    task automatic model_step(output logic [9:0] ex);
        logic [3:0] tk;
        logic [3:0] mc;
        bit acc;
        bit newly[4];
        int idx;
        tk = '0;
        idx = int'(cfg_ch);
        for (int i = 0; i < 4; i++) newly[i] = 1'b0;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                m_clk[i] = 1'b0; m_half[i] = RST[i]; m_rem[i] = RST[i]; m_pend[i] = 1'b0;
            end
            m_halt = 1'b0;
            m_err = 1'b0;
        end else begin
            acc = cfg_valid && m_ready(idx);
            m_err = acc && (idx >= 4);
            if (acc && idx < 4) begin
                m_nxt[idx] = int'(cfg_half); m_pend[idx] = 1'b1; newly[idx] = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (resync) begin
                    if (m_pend[i]) begin m_half[i] = m_nxt[i]; m_pend[i] = 1'b0; end
                    m_clk[i] = 1'b0;
                    m_rem[i] = m_half[i];
                end else begin
                    if (m_pend[i] && !newly[i] && !m_clk[i] && m_rem[i] == m_half[i]) begin
                        m_half[i] = m_nxt[i]; m_rem[i] = m_nxt[i]; m_pend[i] = 1'b0;
                    end
                    if (run || step) begin
                        if (m_half[i] == 0) begin
                            m_clk[i] = 1'b0; m_rem[i] = 0;
                        end else if (m_rem[i] == 1) begin
                            if (!m_clk[i]) tk[i] = 1'b1;
                            else if (m_pend[i] && !newly[i]) begin
                                m_half[i] = m_nxt[i]; m_pend[i] = 1'b0;
                            end
                            m_clk[i] = !m_clk[i];
                            m_rem[i] = m_half[i];
                        end else begin
                            m_rem[i] = m_rem[i] - 1;
                        end
                    end
                end
            end
            m_halt = !run;
        end
        for (int i = 0; i < 4; i++) mc[i] = m_clk[i];
        ex = {mc, tk, m_halt, m_err};
    endtask

    // Predict, push, clock, then sample 1 time unit after the edge.
    task automatic drive_cycle();
        logic [9:0] ex;
        model_step(ex);
        sb.push_back(ex);
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) tk_cnt[i] += int'(tick[i]);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) tk_cnt[i] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        run = 1'b1;
        repeat (3) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL reset_sb: got %b exp %b", obs, e); end
        end
        n_chk++;
        if (obs !== 10'd0) begin n_err++; $display("FAIL reset_outputs: got %b exp 0", obs); end
        n_chk++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", cfg_ready); end
        reset = 1'b1;
    endtask

    task automatic test_defaults();
        clear_counts();
        for (int k = 0; k < 16; k++) begin
            cfg_ch = 3'(k);
            #1;
            n_chk++;
            if (cfg_ready !== m_ready(k % 8)) begin
                n_err++; $display("FAIL defaults_ready ch%0d: got %b exp %b", k % 8, cfg_ready, m_ready(k % 8));
            end
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL defaults_sb cyc%0d: got %b exp %b", k, obs, e); end
        end
        cfg_ch = 3'd0;
        n_chk++;
        if (tk_cnt[0] != 8 || tk_cnt[1] != 4 || tk_cnt[2] != 4 || tk_cnt[3] != 2) begin
            n_err++;
            $display("FAIL defaults_ticks: got %0d/%0d/%0d/%0d exp 8/4/4/2", tk_cnt[0], tk_cnt[1], tk_cnt[2], tk_cnt[3]);
        end
    endtask

    task automatic test_reprogram();
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL reprog_wait_sb: got %b exp %b", obs, e); end
            found = tick[1];
        end
        if (!found) begin n_chk++; n_err++; $display("FAIL reprog_wait: tick[1] not seen, exp within 20 cycles"); end
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_half = 8'd3;
        #1;
        n_chk++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reprog_ready_before: got %b exp 1", cfg_ready); end
        drive_cycle(); e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL reprog_accept_sb: got %b exp %b", obs, e); end
        cfg_valid = 1'b0;
        #1;
        n_chk++;
        if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reprog_ready_pending: got %b exp 0", cfg_ready); end
        for (int k = 0; k < 20; k++) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL reprog_sb cyc%0d: got %b exp %b", k, obs, e); end
        end
    endtask

    task automatic test_halt_step();
        run = 1'b0;
        repeat (5) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL halt_idle_sb: got %b exp %b", obs, e); end
        end
        n_chk++;
        if (halted !== 1'b1 || tick !== 4'd0) begin
            n_err++; $display("FAIL halt_state: got halted=%b tick=%b exp 1/0000", halted, tick);
        end
        repeat (3) begin
            step = 1'b1;
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL halt_step_sb: got %b exp %b", obs, e); end
            step = 1'b0;
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL halt_gap_sb: got %b exp %b", obs, e); end
        end
        run = 1'b1;
        step = 1'b1;
        repeat (4) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL halt_resume_sb: got %b exp %b", obs, e); end
        end
        step = 1'b0;
    endtask

    task automatic test_resync();
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL resync_wait_sb: got %b exp %b", obs, e); end
            found = tick[3];
        end
        if (!found) begin n_chk++; n_err++; $display("FAIL resync_wait: tick[3] not seen, exp within 20 cycles"); end
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_half = 8'd3;
        drive_cycle(); e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL resync_cfg3_sb: got %b exp %b", obs, e); end
        cfg_valid = 1'b0;
        drive_cycle(); e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL resync_pre_sb: got %b exp %b", obs, e); end
        resync = 1'b1; cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_half = 8'd5;
        drive_cycle(); e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL resync_pulse_sb: got %b exp %b", obs, e); end
        n_chk++;
        if (clk_out !== 4'd0 || tick !== 4'd0) begin
            n_err++; $display("FAIL resync_zero: got clk_out=%b tick=%b exp 0000/0000", clk_out, tick);
        end
        resync = 1'b0; cfg_valid = 1'b0;
        clear_counts();
        for (int k = 0; k < 30; k++) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL resync_sb cyc%0d: got %b exp %b", k, obs, e); end
        end
        n_chk++;
        if (tk_cnt[0] != 15 || tk_cnt[1] != 5 || tk_cnt[2] != 3 || tk_cnt[3] != 5) begin
            n_err++;
            $display("FAIL resync_ticks: got %0d/%0d/%0d/%0d exp 15/5/3/5", tk_cnt[0], tk_cnt[1], tk_cnt[2], tk_cnt[3]);
        end
    endtask

    task automatic test_cfg_err_disable();
        cfg_valid = 1'b1; cfg_ch = 3'd6; cfg_half = 8'd9;
        #1;
        n_chk++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL err_ready: got %b exp 1", cfg_ready); end
        drive_cycle(); e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL err_sb: got %b exp %b", obs, e); end
        n_chk++;
        if (cfg_err !== 1'b1) begin n_err++; $display("FAIL err_pulse: got %b exp 1", cfg_err); end
        cfg_valid = 1'b0;
        drive_cycle(); e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL err_after_sb: got %b exp %b", obs, e); end
        n_chk++;
        if (cfg_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b exp 0", cfg_err); end
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_half = 8'd0;
        drive_cycle(); e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL disable_cfg_sb: got %b exp %b", obs, e); end
        cfg_valid = 1'b0;
        repeat (4) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL disable_drain_sb: got %b exp %b", obs, e); end
        end
        clear_counts();
        for (int k = 0; k < 8; k++) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL disable_sb cyc%0d: got %b exp %b", k, obs, e); end
        end
        n_chk++;
        if (tk_cnt[0] != 0 || clk_out[0] !== 1'b0) begin
            n_err++; $display("FAIL disable_ch0: got ticks=%0d clk=%b exp 0/0", tk_cnt[0], clk_out[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL rstmid_wait_sb: got %b exp %b", obs, e); end
            found = tick[3];
        end
        if (!found) begin n_chk++; n_err++; $display("FAIL rstmid_wait: tick[3] not seen, exp within 20 cycles"); end
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_half = 8'd7;
        drive_cycle(); e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL rstmid_cfg_sb: got %b exp %b", obs, e); end
        cfg_valid = 1'b0;
        run = 1'b0;
        repeat (2) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL rstmid_halt_sb: got %b exp %b", obs, e); end
        end
        step = 1'b1; reset = 1'b0;
        drive_cycle(); e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL rstmid_reset_sb: got %b exp %b", obs, e); end
        n_chk++;
        if (obs !== 10'd0) begin n_err++; $display("FAIL rstmid_zero: got %b exp 0", obs); end
        #1;
        n_chk++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b exp 1", cfg_ready); end
        reset = 1'b1; step = 1'b0; run = 1'b1;
        clear_counts();
        for (int k = 0; k < 16; k++) begin
            drive_cycle(); e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL rstmid_sb cyc%0d: got %b exp %b", k, obs, e); end
        end
        n_chk++;
        if (tk_cnt[0] != 8 || tk_cnt[1] != 4 || tk_cnt[2] != 4 || tk_cnt[3] != 2) begin
            n_err++;
            $display("FAIL rstmid_ticks: got %0d/%0d/%0d/%0d exp 8/4/4/2", tk_cnt[0], tk_cnt[1], tk_cnt[2], tk_cnt[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_clk[i] = 1'b0; m_rem[i] = RST[i]; m_half[i] = RST[i]; m_nxt[i] = 0; m_pend[i] = 1'b0;
            tk_cnt[i] = 0;
        end
        test_reset();
        test_defaults();
        test_reprogram();
        test_halt_step();
        test_resync();
        test_cfg_err_disable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, exp completion");
        $fatal(1, "watchdog");
    end

endmodule
